// File: rtl/pearl_rr_sched.sv
// Round-robin scheduler sharing one registered AND stage between NREQ requesters.
// Grants are steered into the stage and the result is returned with its owner's ID.
module pearl_rr_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 16,
  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DWIDTH-1:0]   req_data1,
  input  logic [NREQ*DWIDTH-1:0]   req_data2,
  output logic                     pearl_clk_ena,
  output logic [DWIDTH-1:0]        pearl_data1,
  output logic [DWIDTH-1:0]        pearl_data2,
  input  logic [DWIDTH-1:0]        pearl_o_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DWIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]           rsp_id
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] rsp_id_q;
  logic [IDW-1:0] gnt;
  logic           any_valid;
  logic           slot_free;
  logic           fire;
  int unsigned    cand;

  // Scan from ptr upward with wrap; gnt falls back to ptr when nothing is valid.
  always_comb begin
    gnt       = ptr_q;
    any_valid = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_valid && req_valid[cand[IDW-1:0]]) begin
        any_valid = 1'b1;
        gnt       = cand[IDW-1:0];
      end
    end
  end

  assign slot_free = (state_q == StEmpty) || rsp_ready;
  assign fire      = !reset && slot_free && any_valid;

  always_comb begin
    req_ready   = '0;
    pearl_data1 = '0;
    pearl_data2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        req_ready[i] = fire;
        pearl_data1  = req_data1[i*DWIDTH +: DWIDTH];
        pearl_data2  = req_data2[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign pearl_clk_ena = fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      ptr_q    <= '0;
      rsp_id_q <= '0;
    end else if (fire) begin
      state_q  <= StFull;
      rsp_id_q <= gnt;
      ptr_q    <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    end else if (rsp_ready) begin
      state_q  <= StEmpty;
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_data  = pearl_o_data;
  assign rsp_id    = rsp_id_q;

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));
  a_ena_matches   : assert property (@(posedge clk) pearl_clk_ena == (|req_ready));
`endif

endmodule

// File: tb/tb_pearl_rr_sched.sv
// Scoreboard bench for pearl_rr_sched with a behavioural AND stage model.
module tb_pearl_rr_sched;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DWIDTH = 16;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [63:0]       req_data1;
  logic [63:0]       req_data2;
  logic              pearl_clk_ena;
  logic [15:0]       pearl_data1;
  logic [15:0]       pearl_data2;
  logic [15:0]       pearl_o_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [1:0]        rsp_id;

  exp_t exp_q[$];
  exp_t e;
  int   checks;
  int   passed;

  pearl_rr_sched #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data1    (req_data1),
    .req_data2    (req_data2),
    .pearl_clk_ena(pearl_clk_ena),
    .pearl_data1  (pearl_data1),
    .pearl_data2  (pearl_data2),
    .pearl_o_data (pearl_o_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id)
  );

  // Datapath stage: enable-gated AND register sharing the block's reset.
  always_ff @(posedge clk) begin
    if (reset) pearl_o_data <= '0;
    else if (pearl_clk_ena) pearl_o_data <= pearl_data1 & pearl_data2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_data1[i*16 +: 16] = a;
    req_data2[i*16 +: 16] = b;
  endtask

  function automatic exp_t mk_exp(input int i);
    exp_t r;
    r.id   = 2'(i);
    r.data = req_data1[i*16 +: 16] & req_data2[i*16 +: 16];
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 16'h1111 * 16'(i + 1), 16'hFFFF);
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || pearl_clk_ena !== 1'b0 || rsp_valid !== 1'b0)
        $display("FAIL reset_hold: ready=%b ena=%b rsp_valid=%b want 0000/0/0",
                 req_ready, pearl_clk_ena, rsp_valid);
      else passed++;
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || pearl_clk_ena !== 1'b1)
      $display("FAIL reset_first_grant: ready=%b ena=%b want 0001/1", req_ready, pearl_clk_ena);
    else passed++;
    exp_q.push_back(mk_exp(0));
    tick();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL reset_first_rsp: rsp_valid=%b queued=%0d want 1/1", rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data)
        $display("FAIL reset_first_rsp: id=%0d data=%h want %0d/%h", rsp_id, rsp_data, e.id, e.data);
      else passed++;
    end
    tick();
  endtask

  task automatic test_single();
    set_ops(1, 16'hF0F0, 16'hFF00);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || pearl_clk_ena !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL single_grant: ready=%b ena=%b rsp_valid=%b want 0010/1/0",
               req_ready, pearl_clk_ena, rsp_valid);
    else passed++;
    exp_q.push_back(exp_t'({2'd1, 16'hF000}));
    tick();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL single_rsp: rsp_valid=%b queued=%0d want 1/1", rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data)
        $display("FAIL single_rsp: id=%0d data=%h want %0d/%h", rsp_id, rsp_data, e.id, e.data);
      else passed++;
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_drain: rsp_valid=%b want 0", rsp_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [3:0] want;
    reset = 1'b1;
    req_valid = 4'b0000;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 16'h3C5A ^ 16'(i * 16'h0F0F), 16'hA5F0 + 16'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      want = 4'(1 << exp_g[k]);
      checks++;
      if (req_ready !== want)
        $display("FAIL b2b_grant%0d: ready=%b want %b", k, req_ready, want);
      else passed++;
      if (k > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
          $display("FAIL b2b_rsp%0d: rsp_valid=%b queued=%0d want 1/1", k, rsp_valid, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data)
            $display("FAIL b2b_rsp%0d: id=%0d data=%h want %0d/%h",
                     k, rsp_id, rsp_data, e.id, e.data);
          else passed++;
        end
      end
      exp_q.push_back(mk_exp(exp_g[k]));
      tick();
    end
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL b2b_last: rsp_valid=%b queued=%0d want 1/1", rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data)
        $display("FAIL b2b_last: id=%0d data=%h want %0d/%h", rsp_id, rsp_data, e.id, e.data);
      else passed++;
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL b2b_drain: rsp_valid=%b want 0", rsp_valid);
    else passed++;
  endtask

  // Entered with ptr=1 and the stage empty.
  task automatic test_backpressure();
    set_ops(0, 16'h0FF0, 16'h00FF);
    set_ops(2, 16'hBEEF, 16'hF00F);
    set_ops(3, 16'h1357, 16'hFFF0);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) $display("FAIL bp_grant2: ready=%b want 0100", req_ready);
    else passed++;
    exp_q.push_back(mk_exp(2));
    tick();
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL bp_hold%0d: scoreboard empty, want 1 entry", c);
      end else if (rsp_valid !== 1'b1 || rsp_id !== exp_q[0].id || rsp_data !== exp_q[0].data ||
                   req_ready !== 4'b0000 || pearl_clk_ena !== 1'b0) begin
        $display("FAIL bp_hold%0d: v=%b id=%0d data=%h ready=%b ena=%b want 1/%0d/%h/0000/0",
                 c, rsp_valid, rsp_id, rsp_data, req_ready, pearl_clk_ena,
                 exp_q[0].id, exp_q[0].data);
      end else passed++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) $display("FAIL bp_release: ready=%b want 1000", req_ready);
    else passed++;
    checks++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL bp_rsp2: rsp_valid=%b queued=%0d want 1/1", rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data)
        $display("FAIL bp_rsp2: id=%0d data=%h want %0d/%h", rsp_id, rsp_data, e.id, e.data);
      else passed++;
    end
    exp_q.push_back(mk_exp(3));
    tick();
  endtask

  // Entered right after a grant to 3 with requesters 0 and 3 valid.
  task automatic test_wrap();
    logic [3:0] want;
    int g;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req_valid = 4'b0000;
      #1;
      g = (k == 0) ? 0 : 3;
      want = (k == 2) ? 4'b0000 : 4'(1 << g);
      checks++;
      if (req_ready !== want) $display("FAIL wrap_grant%0d: ready=%b want %b", k, req_ready, want);
      else passed++;
      checks++;
      if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL wrap_rsp%0d: rsp_valid=%b queued=%0d want 1/1", k, rsp_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data)
          $display("FAIL wrap_rsp%0d: id=%0d data=%h want %0d/%h", k, rsp_id, rsp_data, e.id, e.data);
        else passed++;
      end
      if (k < 2) exp_q.push_back(mk_exp(g));
      tick();
    end
  endtask

  // Entered with stage empty and ptr=0.
  task automatic test_reset_midop();
    set_ops(0, 16'hCAFE, 16'h0FF0);
    set_ops(1, 16'h7777, 16'h00F3);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1) $display("FAIL midop_pending: rsp_valid=%b want 1", rsp_valid);
    else passed++;
    reset = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0)
      $display("FAIL midop_dropped: rsp_valid=%b id=%0d want 0/0", rsp_valid, rsp_id);
    else passed++;
    checks++;
    if (req_ready !== 4'b0010 || pearl_clk_ena !== 1'b1)
      $display("FAIL midop_regrant: ready=%b ena=%b want 0010/1", req_ready, pearl_clk_ena);
    else passed++;
    exp_q.push_back(mk_exp(1));
    tick();
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL midop_rsp: rsp_valid=%b queued=%0d want 1/1", rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data)
        $display("FAIL midop_rsp: id=%0d data=%h want %0d/%h", rsp_id, rsp_data, e.id, e.data);
      else passed++;
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL midop_drain: rsp_valid=%b queued=%0d want 0/0", rsp_valid, exp_q.size());
    else passed++;
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_data1 = '0;
    req_data2 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pearl_rr_sched.md
Name: pearl_rr_sched

Overview:
Round-robin scheduler that shares one enable-gated AND-register datapath stage (1-cycle latency, holds its value when its clock enable is low) between NREQ requesters. Each requester offers an operand pair on a valid/ready channel. The block steers the granted operands into the stage, generates its clk_ena, and returns the registered result with the requester ID on a single valid/ready response channel. The block sits between requester ports and one datapath stage instance; top level ties the stage's reset to the same reset as this block.

Parameters:
NREQ, 4, number of requesters (2..16); ID width IDW = max(1, clog2(NREQ)), derived locally.
DWIDTH, 16, operand/result width; must match the datapath stage.

Ports:
clk  in  1  clock; all state on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester accept; one-hot or zero.
req_data1  in  NREQ*DWIDTH  operand 1, requester i at bits [i*DWIDTH +: DWIDTH].
req_data2  in  NREQ*DWIDTH  operand 2, same packing.
pearl_clk_ena  out  1  clock enable to the datapath stage.
pearl_data1  out  DWIDTH  operand 1 to the stage.
pearl_data2  out  DWIDTH  operand 2 to the stage.
pearl_o_data  in  DWIDTH  registered result from the stage.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_data  out  DWIDTH  result; equals pearl_o_data.
rsp_id  out  IDW  index of the requester that owns rsp_data.

Behaviour:
- Reset (sync, reset=1 at edge): rsp_valid=0, rsp_id=0, rr pointer ptr=0, state EMPTY. While reset=1: req_ready=0, pearl_clk_ena=0. pearl_data1/2 are don't-care.
- States: EMPTY (no result held in stage) and FULL (stage holds an unconsumed result). rsp_valid = (state==FULL).
- slot_free = (state==EMPTY) | rsp_ready. A grant fires when slot_free and any req_valid.
- Arbitration is combinational: scan req_valid starting at index ptr, ascending with wrap at NREQ-1 -> 0. The first valid index is gnt.
- On fire:
  - req_ready[gnt]=1, all other bits 0.
  - pearl_clk_ena=1.
  - pearl_data1/2 = requester gnt's operands.
  - At the edge: rsp_id<=gnt, ptr<=(gnt+1) mod NREQ, state<=FULL.
- No fire: req_ready=0, pearl_clk_ena=0, so the stage holds its value. pearl_data1/2 are driven from requester ptr's slice (don't-care).
- FULL & rsp_ready & no request valid: state<=EMPTY; ptr unchanged.
- FULL & rsp_ready & request valid: response consumed and next grant issued in the same cycle; state stays FULL. Throughput is 1 result/cycle.
- FULL & !rsp_ready: rsp_valid, rsp_data and rsp_id held stable. pearl_clk_ena=0 keeps rsp_data stable, and no req_ready is asserted.
- Latency: a grant at edge N gives rsp_valid=1 with the result during cycle N+1.
- req_ready never depends combinationally on rsp_valid's own next state. It does depend combinationally on rsp_ready and req_valid (no registered loops).
- Fairness: a continuously valid requester waits at most NREQ-1 grants.
- Reset mid-operation: any held response is dropped (rsp_valid=0 next cycle) and ptr returns to 0. Requesters re-present their requests after reset.
- Optional assertions (simulation only):
  - req_ready is onehot0.
  - rsp_data/rsp_id are stable while rsp_valid & !rsp_ready.
  - pearl_clk_ena == |req_ready.

Test Plan:
- Reset: hold reset 2 cycles with all req_valid=1 -> req_ready=0, pearl_clk_ena=0, rsp_valid=0 throughout. The first grant after release goes to requester 0.
- Single request: req_valid=4'b0010, data1=0xF0F0, data2=0xFF00, rsp_ready=1 -> that cycle req_ready=4'b0010 and pearl_clk_ena=1. Next cycle rsp_valid=1, rsp_data=0xF000, rsp_id=1. The cycle after, rsp_valid=0.
- Back-to-back rotation: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle, rsp_id sequence 0,1,2,3,0.
- Backpressure: requester 2 response pending, rsp_ready=0 for 3 cycles while req 0 and 3 are valid -> rsp_data/rsp_id=2 stable, pearl_clk_ena=0, req_ready=0. On the cycle rsp_ready=1, req_ready=4'b1000 (ptr=3) and the next cycle rsp_id=3.
- Wrap/fairness: after a grant to 3, requesters 0 and 3 valid -> grant 0. Then with 0 and 3 still valid -> grant 3.
- Reset mid-op: assert reset while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0. After release with req_valid=4'b0110, requester 1 is granted first.
